// File: rtl/arm_pipeline_core.sv
// 5-stage ARM-style pipeline skeleton: ROM fetch with PC+4 carried through IF/ID/EXE/MEM/WB.
// Optional macro ARM_IMEM_WRAP_EN: ROM index wraps modulo IMEM_DEPTH instead of returning zero.

module IF_Stage #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned IMEM_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [WORD_WIDTH-1:0] pc_o,
    output logic [WORD_WIDTH-1:0] instruction_o
);
    localparam int unsigned AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

    logic [WORD_WIDTH-1:0] pc_q, pc_d;
    logic [WORD_WIDTH-1:0] pc, instruction;
    logic [WORD_WIDTH-1:0] rom [IMEM_DEPTH];
    logic [WORD_WIDTH-3:0] word_idx;
    logic [AW-1:0]         rom_sel;
    logic                  rom_hit;

    always_comb begin
        for (int unsigned i = 0; i < IMEM_DEPTH; i++) begin
            rom[i] = WORD_WIDTH'(i + 1);
        end
    end

    assign pc_d     = pc_q + WORD_WIDTH'(4);
    assign word_idx = pc_q[WORD_WIDTH-1:2];

`ifdef ARM_IMEM_WRAP_EN
    assign rom_sel = AW'(word_idx % (WORD_WIDTH-2)'(IMEM_DEPTH));
    assign rom_hit = 1'b1;
`else
    assign rom_sel = word_idx[AW-1:0];
    assign rom_hit = (word_idx < (WORD_WIDTH-2)'(IMEM_DEPTH));
`endif

    always_ff @(posedge clk) begin
        if (rst) pc_q <= '0;
        else     pc_q <= pc_d;
    end

    // Past the end of the ROM the fetch yields a NOP bubble; PC keeps advancing.
    assign pc            = pc_d;
    assign instruction   = rom_hit ? rom[rom_sel] : '0;
    assign pc_o          = pc;
    assign instruction_o = instruction;
endmodule

module pipe_reg #(
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] pc_i,
    input  logic [WORD_WIDTH-1:0] instruction_i,
    output logic [WORD_WIDTH-1:0] pc_o,
    output logic [WORD_WIDTH-1:0] instruction_o
);
    logic [WORD_WIDTH-1:0] pc_q, pc_d, instr_q, instr_d;

    assign pc_d    = pc_i;
    assign instr_d = instruction_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign pc_o          = pc_q;
    assign instruction_o = instr_q;
endmodule

module pass_stage #(
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic [WORD_WIDTH-1:0] pc_i,
    input  logic [WORD_WIDTH-1:0] instruction_i,
    output logic [WORD_WIDTH-1:0] pc_o,
    output logic [WORD_WIDTH-1:0] instruction_o
);
    logic [WORD_WIDTH-1:0] pc, instruction;

    assign pc            = pc_i;
    assign instruction   = instruction_i;
    assign pc_o          = pc;
    assign instruction_o = instruction;
endmodule

module wb_stage #(
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic [WORD_WIDTH-1:0] pc_i,
    input  logic [WORD_WIDTH-1:0] instruction_i
);
    // Terminal stage: fields exist for hierarchical observation only.
    logic [WORD_WIDTH-1:0] pc, instruction;

    assign pc          = pc_i;
    assign instruction = instruction_i;
endmodule

module arm_pipeline_core #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned IMEM_DEPTH = 64
) (
    input  logic clk,
    input  logic rst
);
    logic [WORD_WIDTH-1:0] if_pc,  if_instr;
    logic [WORD_WIDTH-1:0] ifid_pc, ifid_instr, id_pc, id_instr;
    logic [WORD_WIDTH-1:0] idex_pc, idex_instr, ex_pc, ex_instr;
    logic [WORD_WIDTH-1:0] exmem_pc, exmem_instr, mem_pc, mem_instr;
    logic [WORD_WIDTH-1:0] memwb_pc, memwb_instr;

    IF_Stage #(.WORD_WIDTH(WORD_WIDTH), .IMEM_DEPTH(IMEM_DEPTH)) IF_Stage_Inst (
        .clk(clk), .rst(rst), .pc_o(if_pc), .instruction_o(if_instr)
    );

    pipe_reg #(.WORD_WIDTH(WORD_WIDTH)) IF_ID_Reg (
        .clk(clk), .rst(rst), .pc_i(if_pc), .instruction_i(if_instr),
        .pc_o(ifid_pc), .instruction_o(ifid_instr)
    );

    pass_stage #(.WORD_WIDTH(WORD_WIDTH)) ID_Stage_Inst (
        .pc_i(ifid_pc), .instruction_i(ifid_instr), .pc_o(id_pc), .instruction_o(id_instr)
    );

    pipe_reg #(.WORD_WIDTH(WORD_WIDTH)) ID_EXE_Reg (
        .clk(clk), .rst(rst), .pc_i(id_pc), .instruction_i(id_instr),
        .pc_o(idex_pc), .instruction_o(idex_instr)
    );

    pass_stage #(.WORD_WIDTH(WORD_WIDTH)) EXE_Stage_Inst (
        .pc_i(idex_pc), .instruction_i(idex_instr), .pc_o(ex_pc), .instruction_o(ex_instr)
    );

    pipe_reg #(.WORD_WIDTH(WORD_WIDTH)) EXE_MEM_Reg (
        .clk(clk), .rst(rst), .pc_i(ex_pc), .instruction_i(ex_instr),
        .pc_o(exmem_pc), .instruction_o(exmem_instr)
    );

    pass_stage #(.WORD_WIDTH(WORD_WIDTH)) MEM_Stage_Inst (
        .pc_i(exmem_pc), .instruction_i(exmem_instr), .pc_o(mem_pc), .instruction_o(mem_instr)
    );

    pipe_reg #(.WORD_WIDTH(WORD_WIDTH)) MEM_WB_Reg (
        .clk(clk), .rst(rst), .pc_i(mem_pc), .instruction_i(mem_instr),
        .pc_o(memwb_pc), .instruction_o(memwb_instr)
    );

    wb_stage #(.WORD_WIDTH(WORD_WIDTH)) WB_Stage_Inst (
        .pc_i(memwb_pc), .instruction_i(memwb_instr)
    );
endmodule

// File: tb/tb_arm_pipeline_core.sv
// Directed bench for arm_pipeline_core: reset, latency, stage skew, mid-run reset, ROM end behaviour.
module tb_arm_pipeline_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    arm_pipeline_core #(.WORD_WIDTH(32), .IMEM_DEPTH(64)) dut (
        .clk(clk),
        .rst(rst)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic [31:0] epc, input logic [31:0] einstr);
        chk({tag, " wb.pc"}, dut.WB_Stage_Inst.pc, epc);
        chk({tag, " wb.instr"}, dut.WB_Stage_Inst.instruction, einstr);
    endtask

    // Expected WB instruction for post-reset edge n (n>=4): fetched word index k = n-4.
    function automatic logic [31:0] exp_instr(input int n);
        int k;
        k = n - 4;
        if (k < 64) return 32'(k + 1);
`ifdef ARM_IMEM_WRAP_EN
        return 32'((k % 64) + 1);
`else
        return 32'd0;
`endif
    endfunction

    initial begin
        // Hold reset for three edges
        rst = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk("rst PC reg", dut.IF_Stage_Inst.pc_q, 32'd0);
            chk("rst IF pc", dut.IF_Stage_Inst.pc, 32'd4);
            chk("rst IF instr", dut.IF_Stage_Inst.instruction, 32'd1);
            chk("rst ID pc", dut.ID_Stage_Inst.pc, 32'd0);
            chk("rst EXE instr", dut.EXE_Stage_Inst.instruction, 32'd0);
            chk("rst MEM pc", dut.MEM_Stage_Inst.pc, 32'd0);
            chk_wb("rst", 32'd0, 32'd0);
        end

        // Release; edges 1..6 of first run
        rst = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            tick();
            if (n <= 3) chk_wb("bubble", 32'd0, 32'd0);
            else        chk_wb("run1", 32'(4 * (n - 3)), 32'(n - 3));
        end
        chk("edge6 PC reg", dut.IF_Stage_Inst.pc_q, 32'd24);

        // One-edge reset mid-run
        rst = 1'b1;
        tick();
        chk_wb("midrst", 32'd0, 32'd0);
        chk("midrst ID instr", dut.ID_Stage_Inst.instruction, 32'd0);
        chk("midrst PC reg", dut.IF_Stage_Inst.pc_q, 32'd0);
        rst = 1'b0;

        // Post-reset sequence repeats; run 70 edges
        for (int n = 1; n <= 70; n++) begin
            tick();
            if (n <= 3) chk_wb("rerun bubble", 32'd0, 32'd0);
            else        chk_wb("rerun", 32'(4 * (n - 3)), exp_instr(n));
            if (n == 8) begin
                chk("skew ID pc", dut.ID_Stage_Inst.pc, 32'd32);
                chk("skew EXE pc", dut.EXE_Stage_Inst.pc, 32'd28);
                chk("skew MEM pc", dut.MEM_Stage_Inst.pc, 32'd24);
                chk("skew WB pc", dut.WB_Stage_Inst.pc, 32'd20);
                chk("skew WB instr", dut.WB_Stage_Inst.instruction, 32'd5);
            end
            if (n == 67) chk_wb("last rom word", 32'd256, 32'd64);
            if (n == 68) begin
`ifdef ARM_IMEM_WRAP_EN
                chk_wb("pc256 fetch", 32'd260, 32'd1);
`else
                chk_wb("pc256 fetch", 32'd260, 32'd0);
`endif
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
